// File: rtl/jk_pkg.sv
// ----------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK register array: mode encodings and the
// 2-bit mode type used by jk_reg_array.
// ----------------------------------------------------------------------------
package jk_pkg;

   typedef enum logic [1:0] {
      JK_MODE_JK    = 2'd0,
      JK_MODE_LOAD  = 2'd1,
      JK_MODE_COUNT = 2'd2,
      JK_MODE_SHIFT = 2'd3
   } jk_mode_e;

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// ----------------------------------------------------------------------------
// jk_cell
// One JK flip-flop bit with global enable and per-bit reset value.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (q <= RST_VAL)
//   en     enable; when 0 the bit holds
//   j, k   JK controls: 00 hold, 01 clear, 10 set, 11 toggle
//   q      stored bit
// ----------------------------------------------------------------------------
module jk_cell #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic j,
   input  logic k,
   output logic q
);

   logic r_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= RST_VAL;
      end else if (en) begin
         unique case ({j, k})
            2'b00:   r_q <= r_q;
            2'b01:   r_q <= 1'b0;
            2'b10:   r_q <= 1'b1;
            default: r_q <= ~r_q;
         endcase
      end
   end

   assign q = r_q;

endmodule : jk_cell

// File: rtl/jk_reg_array.sv
// ----------------------------------------------------------------------------
// jk_reg_array
// Bank of WIDTH JK cells acting as a general state/counter register.
// Every mode is mapped onto per-bit J/K controls so that the cells are the
// only storage for q.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   en          global enable; 0 holds q and clears tc/chg
//   mode        0 JK, 1 LOAD, 2 COUNT, 3 SHIFT
//   j, k        per-bit JK controls (JK mode)
//   d           parallel load data (LOAD mode)
//   ser_in      serial input into bit 0 (SHIFT mode)
//   q, qn       register state and its complement
//   tc          one-cycle pulse after a COUNT wrap from all-ones to zero
//   chg         1 for the cycle after an edge that changed q
//   toggle_cnt  saturating count of changing edges (JK_TOGGLE_CNT_EN only)
//
// Optional feature macro: JK_TOGGLE_CNT_EN adds toggle_cnt.
// ----------------------------------------------------------------------------
module jk_reg_array
   import jk_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter int               CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             tc,
`ifdef JK_TOGGLE_CNT_EN
   output logic [CNT_W-1:0] toggle_cnt,
`endif
   output logic             chg
);

   generate
      if (WIDTH < 2 || CNT_W < 1) begin : g_param_check
         $error("jk_reg_array: WIDTH must be >= 2 and CNT_W >= 1");
      end
   endgenerate

   jk_mode_e         w_mode;
   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic [WIDTH-1:0] w_carry;
   logic [WIDTH-1:0] w_shift_src;
   logic             w_chg_nxt;
   logic             w_tc_nxt;
   logic             r_tc;
   logic             r_chg;

   assign w_mode = jk_mode_e'(mode);

   // Ripple carry for COUNT: bit i toggles only when all lower bits are 1.
   assign w_carry[0] = 1'b1;
   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_carry
         assign w_carry[gi] = &w_q[gi-1:0];
      end
   endgenerate

   assign w_shift_src = {w_q[WIDTH-2:0], ser_in};

   always_comb begin
      w_j = '0;
      w_k = '0;
      unique case (w_mode)
         JK_MODE_JK: begin
            w_j = j;
            w_k = k;
         end
         JK_MODE_LOAD: begin
            w_j = d;
            w_k = ~d;
         end
         JK_MODE_COUNT: begin
            w_j = w_carry;
            w_k = w_carry;
         end
         default: begin
            w_j = w_shift_src;
            w_k = ~w_shift_src;
         end
      endcase
   end

   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         jk_cell #(
            .RST_VAL (RESET_VAL[gi])
         ) u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .j     (w_j[gi]),
            .k     (w_k[gi]),
            .q     (w_q[gi])
         );
      end
   endgenerate

   // A JK bit changes exactly when it is 0 with J set, or 1 with K set,
   // so the change flag is derived from the controls without a shadow copy.
   assign w_chg_nxt = en & (|((w_j & ~w_q) | (w_k & w_q)));
   assign w_tc_nxt  = en & (w_mode == JK_MODE_COUNT) & (&w_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tc  <= 1'b0;
         r_chg <= 1'b0;
      end else begin
         r_tc  <= w_tc_nxt;
         r_chg <= w_chg_nxt;
      end
   end

`ifdef JK_TOGGLE_CNT_EN
   logic [CNT_W-1:0] r_toggle_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_toggle_cnt <= '0;
      end else if (en && w_mode == JK_MODE_LOAD) begin
         r_toggle_cnt <= '0;
      end else if (w_chg_nxt && !(&r_toggle_cnt)) begin
         r_toggle_cnt <= r_toggle_cnt + 1'b1;
      end
   end

   assign toggle_cnt = r_toggle_cnt;
`endif

   assign q   = w_q;
   assign qn  = ~w_q;
   assign tc  = r_tc;
   assign chg = r_chg;

endmodule : jk_reg_array

// File: tb/tb_jk_reg_array.sv
// ----------------------------------------------------------------------------
// tb_jk_reg_array
// Directed self-checking bench for jk_reg_array (WIDTH=8, CNT_W=2).
// Define JK_TOGGLE_CNT_EN for both files to exercise toggle_cnt.
// ----------------------------------------------------------------------------
module tb_jk_reg_array;
   import jk_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = 2;

   logic             clk;
   logic             reset;
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] d;
   logic             ser_in;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qn;
   logic             tc;
   logic             chg;
`ifdef JK_TOGGLE_CNT_EN
   logic [CNT_W-1:0] toggle_cnt;
`endif

   int n_tests;
   int n_fail;

   jk_reg_array #(
      .WIDTH     (WIDTH),
      .RESET_VAL (8'h00),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .j          (j),
      .k          (k),
      .d          (d),
      .ser_in     (ser_in),
      .q          (q),
      .qn         (qn),
      .tc         (tc),
`ifdef JK_TOGGLE_CNT_EN
      .toggle_cnt (toggle_cnt),
`endif
      .chg        (chg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] m, input logic [7:0] jj, input logic [7:0] kk,
                        input logic [7:0] dd, input logic si);
      mode   = m;
      j      = jj;
      k      = kk;
      d      = dd;
      ser_in = si;
   endtask

   initial begin
      logic [7:0] cnt_exp [5];
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      en      = 1'b0;
      drive(2'd0, 8'h00, 8'h00, 8'h00, 1'b0);

      // 1. reset and JK mode
      #13;
      chk("rst_q",   {24'd0, q},  32'h00);
      chk("rst_qn",  {24'd0, qn}, 32'hFF);
      chk("rst_tc",  {31'd0, tc}, 32'd0);
      chk("rst_chg", {31'd0, chg}, 32'd0);
      reset = 1'b1;
      en    = 1'b1;
      drive(JK_MODE_LOAD, 8'h00, 8'h00, 8'hAA, 1'b0);
      step();
      chk("load_q",   {24'd0, q},  32'hAA);
      chk("load_chg", {31'd0, chg}, 32'd1);
      drive(JK_MODE_JK, 8'hF0, 8'hCC, 8'h00, 1'b0);
      step();
      chk("jk_q",   {24'd0, q},  32'h72);
      chk("jk_qn",  {24'd0, qn}, 32'h8D);
      chk("jk_chg", {31'd0, chg}, 32'd1);

      // 2. count wrap
      drive(JK_MODE_LOAD, 8'h00, 8'h00, 8'hFE, 1'b0);
      step();
      drive(JK_MODE_COUNT, 8'h00, 8'h00, 8'h00, 1'b0);
      step();
      chk("cnt1_q",   {24'd0, q},  32'hFF);
      chk("cnt1_tc",  {31'd0, tc}, 32'd0);
      chk("cnt1_chg", {31'd0, chg}, 32'd1);
      step();
      chk("cnt2_q",   {24'd0, q},  32'h00);
      chk("cnt2_tc",  {31'd0, tc}, 32'd1);
      chk("cnt2_chg", {31'd0, chg}, 32'd1);
      step();
      chk("cnt3_q",   {24'd0, q},  32'h01);
      chk("cnt3_tc",  {31'd0, tc}, 32'd0);
      chk("cnt3_chg", {31'd0, chg}, 32'd1);

      // 3. shift
      drive(JK_MODE_LOAD, 8'h00, 8'h00, 8'h81, 1'b0);
      step();
      drive(JK_MODE_SHIFT, 8'h00, 8'h00, 8'h00, 1'b1);
      step();
      chk("sh1_q", {24'd0, q}, 32'h03);
      step();
      chk("sh2_q", {24'd0, q}, 32'h07);
      ser_in = 1'b0;
      step();
      chk("sh3_q", {24'd0, q}, 32'h0E);

      // 4. enable hold
      drive(JK_MODE_LOAD, 8'h00, 8'h00, 8'h5A, 1'b0);
      step();
      en = 1'b0;
      for (int m = 0; m < 4; m++) begin
         drive(2'(m), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
         step();
         chk("hold_q",   {24'd0, q},  32'h5A);
         chk("hold_chg", {31'd0, chg}, 32'd0);
         chk("hold_tc",  {31'd0, tc}, 32'd0);
      end
      en = 1'b1;
      drive(JK_MODE_JK, 8'h00, 8'h00, 8'hFF, 1'b1);
      step();
      chk("jk00_q",   {24'd0, q},  32'h5A);
      chk("jk00_chg", {31'd0, chg}, 32'd0);

      // 5. asynchronous reset mid-count
      drive(JK_MODE_LOAD, 8'h00, 8'h00, 8'h10, 1'b0);
      step();
      drive(JK_MODE_COUNT, 8'h00, 8'h00, 8'h00, 1'b0);
      step();
      chk("pre_rst_q", {24'd0, q}, 32'h11);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_q",   {24'd0, q},  32'h00);
      chk("arst_chg", {31'd0, chg}, 32'd0);
      #1;
      reset = 1'b1;
      step();
      chk("resume_q",   {24'd0, q},  32'h01);
      chk("resume_chg", {31'd0, chg}, 32'd1);

`ifdef JK_TOGGLE_CNT_EN
      // 6. toggle counter saturation with CNT_W=2
      cnt_exp = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
      drive(JK_MODE_LOAD, 8'h00, 8'h00, 8'h00, 1'b0);
      step();
      chk("tcnt_load0", {30'd0, toggle_cnt}, 32'd0);
      drive(JK_MODE_COUNT, 8'h00, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("tcnt_cnt", {30'd0, toggle_cnt}, {24'd0, cnt_exp[i]});
      end
      chk("tcnt_q", {24'd0, q}, 32'h05);
      drive(JK_MODE_LOAD, 8'h00, 8'h00, 8'h33, 1'b0);
      step();
      chk("tcnt_load1", {30'd0, toggle_cnt}, 32'd0);
`else
      cnt_exp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_jk_reg_array

// File: doc/jk_reg_array.md
Name: jk_reg_array

Overview:
- Parametrised bank of WIDTH JK flip-flops with shared clock, asynchronous active-low reset and a global enable.
- Successor to the single-bit JK flip-flop: adds per-bit JK control, parallel load, synchronous up-count and serial shift modes.
- Adds a registered wrap flag and a change flag.
- Used as a general state/counter register in small control datapaths.

Parameters:
- WIDTH, 8, number of JK cells; must be >= 2.
- RESET_VAL, {WIDTH{1'b0}}, value of q while reset is asserted.
- CNT_W, 16, width of toggle_cnt (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) forces all state immediately; deassertion is synchronised externally.
- en  input  1  global enable. When 0, all state holds.
- mode  input  2  operating mode: 0 JK, 1 LOAD, 2 COUNT, 3 SHIFT.
- j  input  WIDTH  per-bit J inputs; used in JK mode only.
- k  input  WIDTH  per-bit K inputs; used in JK mode only.
- d  input  WIDTH  parallel load data.
- ser_in  input  1  serial input, shifted into bit 0.
- q  output  WIDTH  register state.
- qn  output  WIDTH  bitwise complement of q (combinational).
- tc  output  1  registered wrap pulse.
- chg  output  1  registered "state changed on last edge" flag.

Behaviour:
- Reset asserted (reset=0), with no clock edge required:
  - q=RESET_VAL, qn=~RESET_VAL, tc=0, chg=0.
  - Holds for as long as reset=0.
- All updates occur on the rising edge of clk with 1-cycle latency. Inputs are sampled at that edge.
- en=0: q holds, tc<=0, chg<=0. mode, j, k, d and ser_in are ignored.
- en=1, mode JK: per bit i, (j[i],k[i]) selects:
  - 00: hold.
  - 01: clear to 0.
  - 10: set to 1.
  - 11: toggle.
- en=1, mode LOAD: q<=d.
- en=1, mode COUNT:
  - q<=q+1, modulo 2^WIDTH.
  - Realised with JK cells: bit i toggles when bits [i-1:0] are all 1; bit 0 always toggles.
- en=1, mode SHIFT: q<={q[WIDTH-2:0], ser_in}. The MSB is discarded.
- tc: set to 1 for exactly one cycle after an edge where mode=COUNT, en=1 and q was all-ones (q becomes 0). Otherwise 0.
- chg: 1 for the cycle after any edge where the new q differs from the old q; else 0.
- Mode changes take effect at the next edge. There is no internal state beyond q, tc, chg and the optional counter, so switching modes needs no drain.
- If reset is asserted mid-operation (any mode), the reset values above override immediately. The first edge after deassertion operates normally.

Optional Feature:
- Macro: JK_TOGGLE_CNT_EN.
- When defined:
  - Adds output toggle_cnt (CNT_W bits).
  - Increments on every edge where chg would be set; saturates at all-ones (no wrap).
  - Cleared to 0 by reset, and on any edge with en=1 and mode=LOAD (the LOAD itself is not counted).
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package jk_pkg:
  - Mode encodings: JK_MODE_JK=2'd0, JK_MODE_LOAD=2'd1, JK_MODE_COUNT=2'd2, JK_MODE_SHIFT=2'd3.
  - The 2-bit mode typedef.
- Sub-module jk_cell: one JK bit with clk, reset (async active-low), en, j, k, q and a per-bit reset value.
  - jk_reg_array derives each cell's j/k from mode:
    - LOAD: j=d, k=~d.
    - COUNT: j=k=carry-in.
    - SHIFT: j=src, k=~src.
  - Generate-loop WIDTH instances.

Test Plan:
1. Reset and JK mode:
   - reset=0 -> q=8'h00, tc=0, chg=0.
   - Release reset; LOAD d=8'hAA -> q=8'hAA, chg=1.
   - JK with j=8'hF0, k=8'hCC -> q=8'h72 one cycle later, chg=1.
2. Count wrap:
   - LOAD 8'hFE, then COUNT for 3 edges -> q=8'hFF, 8'h00, 8'h01.
   - tc=1 only in the cycle q=8'h00; chg=1 each cycle.
3. Shift:
   - LOAD 8'h81, then SHIFT with ser_in=1 for two edges -> q=8'h03, then 8'h07.
   - A further edge with ser_in=0 -> q=8'h0E.
4. Enable hold:
   - q=8'h5A, en=0, cycle all four modes with random j/k/d -> q stays 8'h5A, chg=0, tc=0.
   - Re-enable JK with j=k=0 -> q=8'h5A, chg=0.
5. Asynchronous reset mid-count:
   - COUNT from 8'h10; drop reset between clock edges -> q=RESET_VAL before the next edge.
   - Release reset -> counting resumes from 8'h01 on the first edge.
6. JK_TOGGLE_CNT_EN, with CNT_W=2:
   - LOAD 8'h00, then COUNT 5 edges -> toggle_cnt = 1, 2, 3, 3, 3 (saturates).
   - LOAD -> toggle_cnt=0.
